// File: rtl/memory_access_responder.sv
// Memory-side responder: checks each request against the memory map and privilege
// mode, performs at most one synchronous RAM access, and returns data or a fault.
module memory_access_responder #(
  parameter int ADDR_WIDTH            = 14,
  parameter int DATA_WIDTH            = 32,
  parameter int CODE_AREA_SIZE        = 4096,
  parameter int PRIVILEGED_STACK_SIZE = 2048,
  parameter int USER_STACK_SIZE       = 2048,
  parameter int DATA_AREA_SIZE        = 8192
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [1:0]            req_kind,
  input  logic                  req_write,
  input  logic [DATA_WIDTH-1:0] req_address,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic                  privilege_mode_flag,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_fault,
  output logic [1:0]            resp_fault_code,
  output logic [7:0]            fault_count,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_write_enable,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);
  localparam logic [DATA_WIDTH-1:0] CODE_END  = DATA_WIDTH'(CODE_AREA_SIZE);
  localparam logic [DATA_WIDTH-1:0] PSTK_END  = DATA_WIDTH'(CODE_AREA_SIZE + PRIVILEGED_STACK_SIZE);
  localparam logic [DATA_WIDTH-1:0] USTK_BASE = DATA_WIDTH'(DATA_AREA_SIZE - USER_STACK_SIZE);
  localparam logic [DATA_WIDTH-1:0] DATA_BASE = DATA_WIDTH'(DATA_AREA_SIZE);

  localparam logic [1:0] K_LS = 2'd0, K_PUSH = 2'd1, K_POP = 2'd2, K_FETCH = 2'd3;
  localparam logic [1:0] F_NONE = 2'd0, F_WP = 2'd1, F_PRIV = 2'd2, F_REGION = 2'd3;

  typedef enum logic [1:0] {IDLE, ACCESS, CAPTURE, RESP} state_t;

  state_t     state, state_nx;
  logic       wr_q;
  logic       accept, eff_write, in_map, in_code, in_pstk, in_ustk, stack_op;
  logic [1:0] fcode;

  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == RESP);
  assign accept     = req_valid && req_ready;

  // Request decode and fault priority: region > privilege > write-protect.
  always_comb begin
    eff_write = 1'b0;
    fcode     = F_NONE;
    stack_op  = (req_kind == K_PUSH) || (req_kind == K_POP);
    in_map    = ~|req_address[DATA_WIDTH-1:ADDR_WIDTH];
    in_code   = req_address < CODE_END;
    in_pstk   = (req_address >= CODE_END) && (req_address < PSTK_END);
    in_ustk   = (req_address >= USTK_BASE) && (req_address < DATA_BASE);
    case (req_kind)
      K_LS:    eff_write = req_write;
      K_PUSH:  eff_write = 1'b1;
      default: eff_write = 1'b0;
    endcase
    if (!in_map)
      fcode = F_REGION;
    else if (stack_op && (privilege_mode_flag ? !in_pstk : !(in_ustk || in_pstk)))
      fcode = F_REGION;
    else if ((req_kind == K_FETCH) && !in_code)
      fcode = F_REGION;
    else if (!privilege_mode_flag && in_pstk)
      fcode = F_PRIV;
    else if (!privilege_mode_flag && eff_write && in_code)
      fcode = F_WP;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = (fcode != F_NONE) ? RESP : ACCESS;
      ACCESS:  state_nx = wr_q ? RESP : CAPTURE;
      CAPTURE: state_nx = RESP;
      RESP:    if (resp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state            <= IDLE;
      wr_q             <= 1'b0;
      mem_address      <= '0;
      mem_wdata        <= '0;
      mem_write_enable <= 1'b0;
      resp_rdata       <= '0;
      resp_fault       <= 1'b0;
      resp_fault_code  <= F_NONE;
      fault_count      <= '0;
    end else begin
      state            <= state_nx;
      mem_write_enable <= 1'b0;
      if (accept) begin
        resp_rdata      <= '0;
        resp_fault      <= (fcode != F_NONE);
        resp_fault_code <= fcode;
        if (fcode != F_NONE) begin
          if (fault_count != 8'hFF) fault_count <= fault_count + 8'd1;
        end else begin
          // RAM address/strobe are registered here so they appear in ACCESS.
          mem_address <= req_address[ADDR_WIDTH-1:0];
          wr_q        <= eff_write;
          if (eff_write) begin
            mem_write_enable <= 1'b1;
            mem_wdata        <= req_wdata;
          end
        end
      end
      if (state == CAPTURE) resp_rdata <= mem_rdata;
    end
  end
endmodule

// File: doc/memory_access_responder.md
Name: memory_access_responder

Overview:
- Memory-side responder for addresses produced by the CPU's address-handling logic: load/store, push, pop and instruction fetch.
- Each request is checked against the memory map and the privilege mode, then performs at most one access to the synchronous word RAM.
- Returns read data or a fault code through a valid/ready response handshake.
- Sits between the datapath and the single-port data RAM.

Parameters:
ADDR_WIDTH, 14, RAM word-address width.
DATA_WIDTH, 32, data and request-address width.
CODE_AREA_SIZE, 4096, code region is [0, CODE_AREA_SIZE).
PRIVILEGED_STACK_SIZE, 2048, privileged stack region is [CODE_AREA_SIZE, CODE_AREA_SIZE+PRIVILEGED_STACK_SIZE).
USER_STACK_SIZE, 2048, user stack region is the next USER_STACK_SIZE words, ending at DATA_AREA_SIZE-1.
DATA_AREA_SIZE, 8192, data region is [DATA_AREA_SIZE, 2**ADDR_WIDTH).

Ports:
clock  input  1  system clock, rising edge.
reset  input  1  synchronous, active-high.
req_valid  input  1  request present.
req_ready  output  1  responder can accept; high only in IDLE.
req_kind  input  2  0 load/store, 1 push, 2 pop, 3 fetch.
req_write  input  1  1 = store; used only when req_kind=0.
req_address  input  DATA_WIDTH  word address.
req_wdata  input  DATA_WIDTH  store/push data.
privilege_mode_flag  input  1  1 = privileged; sampled at acceptance.
resp_valid  output  1  response present.
resp_ready  input  1  consumer takes the response.
resp_rdata  output  DATA_WIDTH  read data; 0 for writes and faults.
resp_fault  output  1  request rejected.
resp_fault_code  output  2  0 none, 1 write-protect, 2 privilege, 3 region.
fault_count  output  8  saturating count of faulted requests.
mem_address  output  ADDR_WIDTH  RAM address, registered.
mem_wdata  output  DATA_WIDTH  RAM write data, registered.
mem_write_enable  output  1  RAM write strobe, registered, one cycle.
mem_rdata  input  DATA_WIDTH  RAM read data, valid one cycle after the address.

Behaviour:
- Reset: state IDLE. req_ready=1 (IDLE). All other outputs 0, including fault_count. A reset in any state abandons the transaction: no response, and mem_write_enable is low after the reset edge.
- Acceptance happens when req_valid and req_ready are both high (cycle N). At acceptance, latch kind, address, wdata and privilege. Effective write: push=1, pop/fetch=0, kind 0 uses req_write.
- Checks are evaluated at acceptance. A region fault has priority over a privilege fault, which has priority over a write-protect fault.
  - Region fault (3): any bit of req_address at or above ADDR_WIDTH is set, including the 0xFFFFFFFF empty-stack sentinel. Also: push/pop outside the current mode's stack region, or fetch outside the code region.
  - Privilege fault (2): user mode accessing the privileged stack region.
  - Write-protect fault (1): user-mode write to the code region. Privileged writes to code are allowed.
- FSM:
  - IDLE: on acceptance with a fault, go to RESP with resp_fault=1, the code set and no RAM activity; fault_count increments, saturating at 255. Otherwise go to ACCESS.
  - ACCESS (cycle N+1): mem_address = latched address[ADDR_WIDTH-1:0]. If writing, mem_write_enable=1 and mem_wdata=latched wdata, then go to RESP. If reading, go to CAPTURE.
  - CAPTURE (N+2): register mem_rdata into resp_rdata, then go to RESP.
  - RESP: resp_valid=1. Data and fault fields stay stable until resp_ready. On resp_valid && resp_ready, go to IDLE.
- Latency from acceptance to resp_valid: fault N+1, write N+2, read N+3.
- No pipelining: one outstanding request; req_ready is low outside IDLE.
- mem_write_enable is never high for more than one consecutive cycle per request. mem_address holds its last value when idle.

Test Plan:
1. User load at 8192, RAM[8192]=0xDEADBEEF, accepted at cycle 0 -> resp_valid at cycle 3, rdata=0xDEADBEEF, fault=0.
2. User store to address 100 -> resp at cycle 1 with fault=1, code=1. mem_write_enable never high; fault_count=1.
3. User push at 4100 -> fault code 2. Privileged push at 4100 with wdata 0x12345678 -> one write pulse at mem_address 4100, resp at cycle 2 with fault=0.
4. Pop at 0xFFFFFFFF -> code 3. Fetch at 5000 -> code 3. User pop at 6144 -> read succeeds.
5. resp_ready held low for 5 cycles -> resp_valid, rdata and fault fields stable and req_ready=0 throughout. Back-to-back requests then accepted on the first IDLE cycle.
6. Reset asserted in ACCESS of a write -> no response; all outputs 0 after the edge. 300 faulted requests -> fault_count=255.
